pbus_bridge: RTL and testbench

Parametrised Wishbone peripheral-bus bridge, successor to the fixed on-chip config-bank decoder. It sits between the core's 8-bit data-side Wishbone master and N_SLV peripheral slaves, with a parametrised address map, registered slave strobes and a transaction state machine that waits on slave ACK. It adds a timeout watchdog and a sticky bus-error capture with interrupt, so unmapped or hung accesses terminate instead of stalling the core.

---
 rtl/pbus_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_pbus_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_bridge.sv
// ---------------------------------------------------------------------------
// pbus_bridge
//   Wishbone peripheral-bus bridge between the core's data-side master and
//   N_SLV peripheral slaves. Decodes the master address against a
//   parametrised base/mask map, drives a registered one-hot strobe to the
//   selected slave and waits for its ACK. A watchdog terminates hung
//   accesses and unmapped accesses terminate with an error; the first error
//   is held in a sticky capture register that also drives an interrupt.
//
// Ports
//   clk, rst            core clock, asynchronous active-low reset
//   WB_ADRi/DATi/WEi    master address, write data, write enable
//   WB_CYCi/STBi        master cycle and strobe
//   WB_DATo             registered read data
//   WB_ACKo/ERRo        one-cycle normal / error termination
//   S_ADRo/DATo/WEo     registered address, data, write enable to slaves
//   S_CYCo              high while a slave access is in progress
//   S_STBo              one-hot strobe to the selected slave
//   S_DATi/ACKi         flattened slave read data and acknowledges
//   ERR_CLR             clears the error capture
//   ERR_VLD/CODE/ADR    sticky error flag, cause (0 miss, 1 timeout), address
//   BUSERR_INT          interrupt request, mirrors ERR_VLD
// ---------------------------------------------------------------------------
module pbus_bridge #(
  parameter int                     N_SLV    = 5,
  parameter int                     ADR_W    = 12,
  parameter int                     DAT_W    = 8,
  parameter logic [N_SLV*ADR_W-1:0] SLV_BASE = {N_SLV*ADR_W{1'b0}},
  parameter logic [N_SLV*ADR_W-1:0] SLV_MASK = {N_SLV*ADR_W{1'b0}},
  parameter int                     TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADR_W-1:0]       WB_ADRi,
  input  logic [DAT_W-1:0]       WB_DATi,
  input  logic                   WB_WEi,
  input  logic                   WB_CYCi,
  input  logic                   WB_STBi,
  output logic [DAT_W-1:0]       WB_DATo,
  output logic                   WB_ACKo,
  output logic                   WB_ERRo,
  output logic [ADR_W-1:0]       S_ADRo,
  output logic [DAT_W-1:0]       S_DATo,
  output logic                   S_WEo,
  output logic                   S_CYCo,
  output logic [N_SLV-1:0]       S_STBo,
  input  logic [N_SLV*DAT_W-1:0] S_DATi,
  input  logic [N_SLV-1:0]       S_ACKi,
  input  logic                   ERR_CLR,
  output logic                   ERR_VLD,
  output logic                   ERR_CODE,
  output logic [ADR_W-1:0]       ERR_ADR,
  output logic                   BUSERR_INT
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SEL_W = (N_SLV < 2) ? 1 : $clog2(N_SLV);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;

  logic             w_req;
  logic             w_hit;
  logic [SEL_W-1:0] w_idx;
  logic [N_SLV-1:0] w_onehot;
  logic             w_ack;
  logic [DAT_W-1:0] w_rdat;
  logic             w_tmo;
  logic             w_err_evt;
  logic             w_err_code;
  logic [ADR_W-1:0] w_err_adr;

  assign w_req = WB_CYCi & WB_STBi;

  // Address decode. Scanning from the top index down lets the lowest
  // matching slave overwrite any higher one, so overlaps resolve to the
  // lowest index.
  always_comb begin
    w_hit    = 1'b0;
    w_idx    = '0;
    w_onehot = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((WB_ADRi & SLV_MASK[i*ADR_W +: ADR_W]) ==
          (SLV_BASE[i*ADR_W +: ADR_W] & SLV_MASK[i*ADR_W +: ADR_W])) begin
        w_hit       = 1'b1;
        w_idx       = SEL_W'(i);
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Only the selected slave's ACK and data are looked at; ACKs from any
  // other channel are ignored.
  assign w_ack  = S_ACKi[r_sel];
  assign w_rdat = S_DATi[int'(r_sel)*DAT_W +: DAT_W];

  // Watchdog fires when the counter reaches TIMEOUT; TIMEOUT = 0 disables it.
  assign w_tmo = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

  // Error entries into RESP: a decode miss straight from IDLE, or a watchdog
  // expiry in ACTIVE that was not beaten by an ACK or a master abort.
  always_comb begin
    w_err_evt  = 1'b0;
    w_err_code = 1'b0;
    w_err_adr  = WB_ADRi;
    if (r_state == ST_IDLE && w_req && !w_hit) begin
      w_err_evt  = 1'b1;
      w_err_code = 1'b0;
      w_err_adr  = WB_ADRi;
    end else if (r_state == ST_ACTIVE && WB_CYCi && !w_ack && w_tmo) begin
      w_err_evt  = 1'b1;
      w_err_code = 1'b1;
      w_err_adr  = S_ADRo;
    end
  end

  // Transaction state machine and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      WB_DATo <= '0;
      WB_ACKo <= 1'b0;
      WB_ERRo <= 1'b0;
      S_ADRo  <= '0;
      S_DATo  <= '0;
      S_WEo   <= 1'b0;
      S_CYCo  <= 1'b0;
      S_STBo  <= '0;
    end else begin
      WB_ACKo <= 1'b0;
      WB_ERRo <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            S_ADRo <= WB_ADRi;
            S_DATo <= WB_DATi;
            S_WEo  <= WB_WEi;
            r_sel  <= w_idx;
            r_cnt  <= '0;
            if (w_hit) begin
              r_state <= ST_ACTIVE;
              S_CYCo  <= 1'b1;
              S_STBo  <= w_onehot;
            end else begin
              r_state <= ST_RESP;
              WB_ERRo <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (!WB_CYCi) begin
            // Master abort: abandon silently.
            r_state <= ST_IDLE;
            S_CYCo  <= 1'b0;
            S_STBo  <= '0;
          end else if (w_ack) begin
            // ACK takes priority over a watchdog expiry in the same cycle.
            if (!S_WEo) begin
              WB_DATo <= w_rdat;
            end
            WB_ACKo <= 1'b1;
            r_state <= ST_RESP;
            S_CYCo  <= 1'b0;
            S_STBo  <= '0;
          end else if (w_tmo) begin
            WB_ERRo <= 1'b1;
            r_state <= ST_RESP;
            S_CYCo  <= 1'b0;
            S_STBo  <= '0;
          end else if (r_cnt != {CNT_W{1'b1}}) begin
            // Saturate rather than wrap; matters only with the watchdog off.
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          S_CYCo  <= 1'b0;
          S_STBo  <= '0;
        end
      endcase
    end
  end

  // Sticky error capture. A clear in the same cycle as a new error frees the
  // register so the new error is the one captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ERR_VLD  <= 1'b0;
      ERR_CODE <= 1'b0;
      ERR_ADR  <= '0;
    end else begin
      if (w_err_evt && (!ERR_VLD || ERR_CLR)) begin
        ERR_VLD  <= 1'b1;
        ERR_CODE <= w_err_code;
        ERR_ADR  <= w_err_adr;
      end else if (ERR_CLR) begin
        ERR_VLD  <= 1'b0;
      end
    end
  end

  assign BUSERR_INT = ERR_VLD;

endmodule

// File: tb/tb_pbus_bridge.sv
module tb_pbus_bridge;

  localparam int N   = 5;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int TMO = 15;

  // slave 4: 0x9A8-0x9AF, 3: 0x180-0x1BF (inside slave 0), 2: 0x600-0x603,
  // 1: 0x200-0x2FF, 0: 0x100-0x1FF
  localparam logic [N*AW-1:0] P_BASE = {12'h9A8, 12'h180, 12'h600, 12'h200, 12'h100};
  localparam logic [N*AW-1:0] P_MASK = {12'hFF8, 12'hFC0, 12'hFFC, 12'hF00, 12'hF00};

  logic            clk;
  logic            rst;
  logic [AW-1:0]   WB_ADRi;
  logic [DW-1:0]   WB_DATi;
  logic            WB_WEi;
  logic            WB_CYCi;
  logic            WB_STBi;
  logic [DW-1:0]   WB_DATo;
  logic            WB_ACKo;
  logic            WB_ERRo;
  logic [AW-1:0]   S_ADRo;
  logic [DW-1:0]   S_DATo;
  logic            S_WEo;
  logic            S_CYCo;
  logic [N-1:0]    S_STBo;
  logic [N*DW-1:0] S_DATi;
  logic [N-1:0]    S_ACKi;
  logic            ERR_CLR;
  logic            ERR_VLD;
  logic            ERR_CODE;
  logic [AW-1:0]   ERR_ADR;
  logic            BUSERR_INT;

  pbus_bridge #(
    .N_SLV(N), .ADR_W(AW), .DAT_W(DW),
    .SLV_BASE(P_BASE), .SLV_MASK(P_MASK), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .WB_ADRi(WB_ADRi), .WB_DATi(WB_DATi), .WB_WEi(WB_WEi),
    .WB_CYCi(WB_CYCi), .WB_STBi(WB_STBi),
    .WB_DATo(WB_DATo), .WB_ACKo(WB_ACKo), .WB_ERRo(WB_ERRo),
    .S_ADRo(S_ADRo), .S_DATo(S_DATo), .S_WEo(S_WEo), .S_CYCo(S_CYCo),
    .S_STBo(S_STBo), .S_DATi(S_DATi), .S_ACKi(S_ACKi),
    .ERR_CLR(ERR_CLR), .ERR_VLD(ERR_VLD), .ERR_CODE(ERR_CODE),
    .ERR_ADR(ERR_ADR), .BUSERR_INT(BUSERR_INT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave models: each ACKs combinationally after sw_wait wait states;
  // stray forces an ACK on a channel regardless of its strobe.
  int           wcnt    [N];
  int           sw_wait [N];
  logic [DW-1:0] sw_dat [N];
  logic [N-1:0] stray;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) wcnt[i] <= S_STBo[i] ? wcnt[i] + 1 : 0;
  end

  always_comb begin
    S_ACKi = '0;
    S_DATi = '0;
    for (int i = 0; i < N; i++) begin
      S_ACKi[i] = (S_STBo[i] && (wcnt[i] == sw_wait[i])) || stray[i];
      S_DATi[i*DW +: DW] = sw_dat[i];
    end
  end

  typedef struct {
    logic          is_err;
    logic [DW-1:0] dat;
    int            cyc;
    logic          evld;
    logic          ecode;
    logic [AW-1:0] eadr;
  } exp_t;

  exp_t sbq[$];
  exp_t me;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  logic          m_vld;
  logic          m_code;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dato;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < N; i++)
      if ((a & P_MASK[i*AW +: AW]) == (P_BASE[i*AW +: AW] & P_MASK[i*AW +: AW])) return i;
    return -1;
  endfunction

  // Monitor: every ACK/ERR pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst && (WB_ACKo || WB_ERRo)) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b, no response expected", WB_ACKo, WB_ERRo);
      end else begin
        me = sbq.pop_front();
        chk("resp_kind", 32'({WB_ACKo, WB_ERRo}), me.is_err ? 32'h1 : 32'h2);
        chk("resp_cycle", 32'(cyc), 32'(me.cyc));
        chk("wb_dato", 32'(WB_DATo), 32'(me.dat));
        chk("err_vld", 32'(ERR_VLD), 32'(me.evld));
        chk("buserr_int", 32'(BUSERR_INT), 32'(me.evld));
        if (me.evld) begin
          chk("err_code", 32'(ERR_CODE), 32'(me.ecode));
          chk("err_adr", 32'(ERR_ADR), 32'(me.eadr));
        end
      end
    end
  end

  // One complete master transaction; starts and ends 1 time unit after a
  // rising edge with the bridge idle.
  task automatic do_txn(input logic [AW-1:0] adr, input logic we,
                        input logic [DW-1:0] wd, input int wt, input logic clr);
    int sel, lat, stb_exp, stb_cnt, n;
    logic is_err, code;
    logic [N-1:0] oh;
    exp_t e;
    sel = decode(adr);
    oh  = '0;
    code = 1'b0;
    if (sel < 0) begin
      is_err = 1'b1; lat = 1; stb_exp = 0;
    end else begin
      oh[sel] = 1'b1;
      sw_wait[sel] = wt;
      sw_dat[sel]  = 8'($urandom);
      if (wt <= TMO) begin
        is_err = 1'b0; lat = 2 + wt; stb_exp = wt + 1;
        if (!we) m_dato = sw_dat[sel];
      end else begin
        is_err = 1'b1; code = 1'b1; lat = TMO + 2; stb_exp = TMO + 1;
      end
    end
    if (clr) m_vld = 1'b0;
    if (is_err && !m_vld) begin
      m_vld = 1'b1; m_code = code; m_adr = adr;
    end
    e.is_err = is_err; e.dat = m_dato; e.cyc = cyc + lat;
    e.evld = m_vld; e.ecode = m_code; e.eadr = m_adr;
    sbq.push_back(e);

    WB_ADRi = adr; WB_DATi = wd; WB_WEi = we; ERR_CLR = clr;
    WB_CYCi = 1'b1; WB_STBi = 1'b1;
    @(posedge clk); #1;
    ERR_CLR = 1'b0;
    chk("s_stbo", 32'(S_STBo), 32'(oh));
    chk("s_cyco", 32'(S_CYCo), 32'(sel >= 0));
    chk("s_adro", 32'(S_ADRo), 32'(adr));
    chk("s_weo", 32'(S_WEo), 32'(we));
    chk("s_dato", 32'(S_DATo), 32'(wd));
    stb_cnt = 0; n = 0;
    while (!(WB_ACKo || WB_ERRo) && n < 40) begin
      if (S_STBo != '0) stb_cnt++;
      @(posedge clk); #1;
      n++;
    end
    chk("resp_seen", 32'(WB_ACKo | WB_ERRo), 32'h1);
    chk("stb_cycles", 32'(stb_cnt), 32'(stb_exp));
    WB_CYCi = 1'b0; WB_STBi = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clr_idle();
    ERR_CLR = 1'b1;
    @(posedge clk); #1;
    ERR_CLR = 1'b0;
    m_vld = 1'b0;
    chk("err_vld_after_clr", 32'(ERR_VLD), 32'(m_vld));
    chk("buserr_int_after_clr", 32'(BUSERR_INT), 32'(m_vld));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_dato"}, 32'(WB_DATo), 0);
    chk({tag, "_wb_acko"}, 32'(WB_ACKo), 0);
    chk({tag, "_wb_erro"}, 32'(WB_ERRo), 0);
    chk({tag, "_s_adro"}, 32'(S_ADRo), 0);
    chk({tag, "_s_dato"}, 32'(S_DATo), 0);
    chk({tag, "_s_weo"}, 32'(S_WEo), 0);
    chk({tag, "_s_cyco"}, 32'(S_CYCo), 0);
    chk({tag, "_s_stbo"}, 32'(S_STBo), 0);
    chk({tag, "_err_vld"}, 32'(ERR_VLD), 0);
    chk({tag, "_err_code"}, 32'(ERR_CODE), 0);
    chk({tag, "_err_adr"}, 32'(ERR_ADR), 0);
    chk({tag, "_buserr_int"}, 32'(BUSERR_INT), 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    int k, r, wt;
    rst = 1'b0;
    WB_ADRi = '0; WB_DATi = '0; WB_WEi = 1'b0; WB_CYCi = 1'b0; WB_STBi = 1'b0;
    ERR_CLR = 1'b0; stray = '0;
    for (int i = 0; i < N; i++) begin sw_wait[i] = 0; sw_dat[i] = '0; end
    m_vld = 1'b0; m_code = 1'b0; m_adr = '0; m_dato = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Read hit, zero wait
    do_txn(12'h602, 1'b0, 8'h00, 0, 1'b0);
    // Write with 3 wait states
    do_txn(12'h9AB, 1'b1, 8'hC3, 3, 1'b0);
    // Decode miss
    do_txn(12'h5F0, 1'b0, 8'h11, 0, 1'b0);
    clr_idle();
    // Timeout, then a miss that must not overwrite the capture
    do_txn(12'h234, 1'b0, 8'h22, 255, 1'b0);
    do_txn(12'h7FF, 1'b1, 8'h33, 0, 1'b0);
    clr_idle();
    // ACK exactly on the timeout cycle, then one cycle too late
    do_txn(12'h601, 1'b0, 8'h00, 15, 1'b0);
    do_txn(12'h603, 1'b0, 8'h00, 16, 1'b0);
    // Clear coinciding with a new miss: new error captured
    do_txn(12'hFFF, 1'b0, 8'h00, 0, 1'b1);
    clr_idle();
    // Stray ACKs from non-selected slaves ignored
    stray = 5'b11001;
    do_txn(12'h600, 1'b0, 8'h00, 2, 1'b0);
    stray = '0;
    // Overlap: 0x190 matches slaves 0 and 3, slave 0 must win
    do_txn(12'h190, 1'b0, 8'h00, 1, 1'b0);

    // Master abort in ACTIVE
    sw_wait[1] = 255;
    WB_ADRi = 12'h2A0; WB_WEi = 1'b0; WB_CYCi = 1'b1; WB_STBi = 1'b1;
    @(posedge clk); #1;
    chk("abort_stb", 32'(S_STBo), 32'h2);
    repeat (3) begin @(posedge clk); #1; end
    WB_CYCi = 1'b0; WB_STBi = 1'b0;
    @(posedge clk); #1;
    chk("abort_stb_drop", 32'(S_STBo), 0);
    chk("abort_cyc_drop", 32'(S_CYCo), 0);
    do_txn(12'h1F0, 1'b0, 8'h00, 0, 1'b0);

    // Async reset while ACTIVE, with an error captured beforehand
    do_txn(12'hFFE, 1'b0, 8'h00, 0, 1'b0);
    sw_wait[2] = 255;
    WB_ADRi = 12'h602; WB_DATi = 8'h77; WB_WEi = 1'b1; WB_CYCi = 1'b1; WB_STBi = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_stb", 32'(S_STBo), 32'h4);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    WB_CYCi = 1'b0; WB_STBi = 1'b0; WB_WEi = 1'b0;
    m_vld = 1'b0; m_code = 1'b0; m_adr = '0; m_dato = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_txn(12'h605, 1'b0, 8'h00, 1, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, 5);
      if (k < N) a = (P_BASE[k*AW +: AW] & P_MASK[k*AW +: AW]) |
                     (12'($urandom) & ~P_MASK[k*AW +: AW]);
      else a = 12'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6) wt = r % 5;
      else if (r == 6) wt = 14;
      else if (r == 7) wt = 15;
      else if (r == 8) wt = 16;
      else wt = 255;
      do_txn(a, 1'($urandom), 8'($urandom), wt, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) clr_idle();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
